// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - cnt_width(): width of the bit counter, $clog2(BIN_W+1)
//   - max_value(): largest value representable in DIGITS BCD digits, 10^DIGITS-1
package bin_to_bcd_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // Valid for digits <= 19 so the result fits in 64 bits.
    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Conversion interface for bin_to_bcd_seq.
// Handshake: the requester raises start with bin valid; it is accepted on any
// rising edge where the converter is not busy (IDLE or DONE). busy stays high
// for BIN_W cycles, then done pulses for exactly one cycle with bcd/overflow
// already updated. start while busy is ignored; bcd/overflow hold between
// conversions.
// Signals:
//   start    request a conversion (master -> slave)
//   bin      unsigned binary input, BIN_W bits (master -> slave)
//   busy     conversion in progress (slave -> master)
//   done     one-cycle completion pulse (slave -> master)
//   bcd      packed BCD result, digit i at [4i+3:4i] (slave -> master)
//   overflow input exceeded 10^DIGITS-1, bcd saturated to all nines
//   state    FSM state, debug visibility only
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [1:0]            state;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, state
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, state
    );
endinterface

// File: rtl/bin_to_bcd_seq_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is >= 5,
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit  4-bit scratch digit before the shift
//   fixed  corrected digit
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);
    assign fixed = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the per-digit BCD-to-7-segment decoders of the parking display.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    bin_to_bcd_seq_if slave: start/bin in, busy/done/bcd/overflow/state out
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int          CW    = cnt_width(BIN_W);
    localparam int          SW    = 4 * DIGITS;
    localparam logic [63:0] MAX_V = max_value(DIGITS);

    logic [1:0]       state;
    logic [BIN_W-1:0] shreg;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    scratch_adj;
    logic [SW-1:0]    scratch_next;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;
    logic [SW-1:0]    bcd_q;
    logic             ovf_q;

    // All digits are corrected in parallel on the pre-shift scratch value.
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit (scratch[4*d +: 4]),
            .fixed (scratch_adj[4*d +: 4])
        );
    end

    // Carry out of the top digit is dropped; it can only occur on overflow,
    // which is handled by saturation instead.
    assign scratch_next = {scratch_adj[SW-2:0], shreg[BIN_W-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts start too, giving back-to-back conversions.
                    if (bus.start) begin
                        shreg    <= bus.bin;
                        scratch  <= '0;
                        cnt      <= CW'(BIN_W);
                        ovf_pend <= (64'(bus.bin) > MAX_V);
                        state    <= ST_SHIFT;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Outputs are loaded on the edge entering DONE so they
                        // are already valid while done is high.
                        state <= ST_DONE;
                        bcd_q <= ovf_pend ? {DIGITS{4'h9}} : scratch_next;
                        ovf_q <= ovf_pend;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == ST_SHIFT);
    assign bus.done     = (state == ST_DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq. Two instances share clock
// and reset: an 8-bit/3-digit unit and a 10-bit/3-digit unit for saturation.
module tb_bin_to_bcd_seq;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8 ();
    bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) if10 ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (if10)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs[12];

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sel_done(input bit wide);
        return wide ? if10.done : if8.done;
    endfunction

    function automatic logic sel_busy(input bit wide);
        return wide ? if10.busy : if8.busy;
    endfunction

    function automatic logic [11:0] sel_bcd(input bit wide);
        return wide ? if10.bcd : if8.bcd;
    endfunction

    function automatic logic sel_ovf(input bit wide);
        return wide ? if10.overflow : if8.overflow;
    endfunction

    // Starting from a sample just after the accepting edge (or later), count
    // busy samples until done, bounded by a cycle budget.
    task automatic wait_done(input bit wide, input string name, input int exp_busy);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (!sel_done(wide) && guard < 30) begin
            if (sel_busy(wide)) n++;
            step();
            guard++;
        end
        check({name, "_done_seen"}, 32'(sel_done(wide)), 32'd1);
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    task automatic drive_start(input bit wide, input logic [9:0] b);
        if (wide) begin
            if10.start = 1'b1;
            if10.bin   = b;
        end else begin
            if8.start = 1'b1;
            if8.bin   = b[7:0];
        end
    endtask

    task automatic drop_start();
        if8.start  = 1'b0;
        if10.start = 1'b0;
    endtask

    task automatic convert(input bit wide, input logic [9:0] b, input logic [11:0] exp_bcd,
                           input logic exp_ovf, input int exp_busy, input string name);
        drive_start(wide, b);
        step();
        drop_start();
        wait_done(wide, name, exp_busy);
        check({name, "_bcd"}, 32'(sel_bcd(wide)), 32'(exp_bcd));
        check({name, "_ovf"}, 32'(sel_ovf(wide)), 32'(exp_ovf));
        step();
        check({name, "_done_pulse_len"}, 32'(sel_done(wide)), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;

        vecs[0]  = '{8'd0,   12'h000};
        vecs[1]  = '{8'd1,   12'h001};
        vecs[2]  = '{8'd5,   12'h005};
        vecs[3]  = '{8'd9,   12'h009};
        vecs[4]  = '{8'd10,  12'h010};
        vecs[5]  = '{8'd37,  12'h037};
        vecs[6]  = '{8'd59,  12'h059};
        vecs[7]  = '{8'd99,  12'h099};
        vecs[8]  = '{8'd100, 12'h100};
        vecs[9]  = '{8'd128, 12'h128};
        vecs[10] = '{8'd200, 12'h200};
        vecs[11] = '{8'd255, 12'h255};

        reset     = 1'b1;
        if8.start = 1'b0;
        if8.bin   = '0;
        if10.start = 1'b0;
        if10.bin   = '0;
        step();
        step();
        check("rst_state", 32'(if8.state), 32'd0);
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_bcd", 32'(if8.bcd), 32'd0);
        check("rst_ovf", 32'(if8.overflow), 32'd0);
        check("rst_bcd_w", 32'(if10.bcd), 32'd0);
        reset = 1'b0;
        step();

        // Table-driven conversions on the 8-bit unit.
        for (int i = 0; i < 12; i++) begin
            convert(1'b0, {2'b00, vecs[i].bin}, vecs[i].bcd, 1'b0, 8, $sformatf("vec%0d", i));
        end

        // Result must hold after done with start low.
        for (int i = 0; i < 3; i++) step();
        check("hold_bcd", 32'(if8.bcd), 32'h255);
        check("hold_busy", 32'(if8.busy), 32'd0);
        check("hold_state_idle", 32'(if8.state), 32'd0);

        // Back-to-back: restart in the DONE cycle, no IDLE gap.
        drive_start(1'b0, 10'd99);
        step();
        drop_start();
        wait_done(1'b0, "b2b_first", 8);
        check("b2b_first_bcd", 32'(if8.bcd), 32'h099);
        drive_start(1'b0, 10'd100);
        step();
        drop_start();
        check("b2b_no_gap_busy", 32'(if8.busy), 32'd1);
        wait_done(1'b0, "b2b_second", 8);
        check("b2b_second_bcd", 32'(if8.bcd), 32'h100);
        step();

        // start while busy is ignored.
        drive_start(1'b0, 10'd37);
        step();
        drop_start();
        step();
        step();
        drive_start(1'b0, 10'd200);
        step();
        drop_start();
        wait_done(1'b0, "busy_start", 5);
        check("busy_start_bcd", 32'(if8.bcd), 32'h037);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if8.done) seen++;
        end
        check("busy_start_single_done", 32'(seen), 32'd0);

        // Reset mid-conversion aborts without a done pulse.
        drive_start(1'b0, 10'd180);
        step();
        drop_start();
        step();
        step();
        step();
        check("abort_busy_before", 32'(if8.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(if8.busy), 32'd0);
        check("abort_bcd", 32'(if8.bcd), 32'd0);
        check("abort_done", 32'(if8.done), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if8.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        convert(1'b0, 10'd42, 12'h042, 1'b0, 8, "after_abort");

        // Wide unit: saturation and the largest in-range value.
        convert(1'b1, 10'd1023, 12'h999, 1'b1, 10, "w_sat");
        convert(1'b1, 10'd999,  12'h999, 1'b0, 10, "w_999");
        convert(1'b1, 10'd1000, 12'h999, 1'b1, 10, "w_1000");
        convert(1'b1, 10'd512,  12'h512, 1'b0, 10, "w_512");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
